piso_arb_ctrl: RTL



---
 rtl/piso_pkg.sv | 41 ++++
 rtl/piso_shift.sv | 26 ++
 rtl/piso_arb_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types, frame geometry and round-robin pick for the PISO sequencer.
// PISO_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam int unsigned W_DEF = 4;
`ifdef PISO_PARITY_EN
  localparam int unsigned PAR_BITS = 1;
`else
  localparam int unsigned PAR_BITS = 0;
`endif
  localparam int unsigned FRAME_LEN = W_DEF + PAR_BITS;

  // Fixed-width search space so one function serves any NREQ up to MAX_REQ
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo nreq
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int unsigned        nreq);
    pick_t       p;
    int unsigned i;
    p = '0;
    for (int unsigned off = 0; off < MAX_REQ; off++) begin
      i = (32'(ptr) + off) % nreq;
      if (off < nreq && !p.found && valid[IDX_W'(i)]) begin
        p.found = 1'b1;
        p.idx   = IDX_W'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/piso_shift.sv
// W-bit parallel-load / shift-left register; sl=1 loads, sl=0 shifts in zero.
module piso_shift #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sl,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic         sout
);

  logic [W-1:0] q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      if (sl) q <= din;
      else    q <= {q[W-2:0], 1'b0};
    end
  end

  assign sout = q[W-1];

endmodule

// File: rtl/piso_arb_ctrl.sv
// Round-robin arbiter and sequencer feeding nibbles MSB-first into the serial stream.
// Build with PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_arb_ctrl
  import piso_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned NREQ = 2,
  parameter int unsigned SW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              ser_first,
  output logic              ser_last,
  output logic [SW-1:0]     ser_src,
  output logic              busy
);

  localparam int unsigned FL     = W + PAR_BITS;
  localparam int unsigned CW     = $clog2(FL + 1);
  localparam int unsigned DIDX_W = $clog2(NREQ * W);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] ptr_q, ptr_d;
  pick_t         pick;
  logic          accept_win, hs, sl, sh_en, sout;
  logic [W-1:0]  sel_data;

  assign accept_win = (state_q == IDLE) || (state_q == SHIFT && cnt_q == LAST);

  // Grant and data mux; ready is forced low while reset is asserted
  always_comb begin
    pick      = rr_pick(MAX_REQ'(req_valid), IDX_W'(ptr_q), NREQ);
    hs        = accept_win && pick.found;
    sel_data  = '0;
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick.idx == IDX_W'(i)) begin
        sel_data          = req_data[DIDX_W'(i * W) +: W];
        req_ready[SW'(i)] = hs && rst_n;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sl      = 1'b0;
    sh_en   = 1'b0;
    if (hs) begin
      state_d = SHIFT;
      cnt_d   = '0;
      ptr_d   = SW'((32'(pick.idx) + 32'd1) % NREQ);
      sl      = 1'b1;
      sh_en   = 1'b1;
    end else if (state_q == SHIFT) begin
      sh_en = 1'b1;
      if (cnt_q == LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      ser_last  <= 1'b0;
      ser_src   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      ser_valid <= (state_d == SHIFT);
      ser_first <= hs;
      ser_last  <= (state_d == SHIFT) && (cnt_d == LAST);
      if (hs) ser_src <= SW'(pick.idx);
    end
  end

  assign busy = ser_valid;

  piso_shift #(.W(W)) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .sl    (sl),
    .en    (sh_en),
    .din   (sel_data),
    .sout  (sout)
  );

`ifdef PISO_PARITY_EN
  logic par_q;

  // Parity of the loaded nibble, sent once the data bits have drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  par_q <= 1'b0;
    else if (hs) par_q <= ^sel_data;
  end

  assign ser_out = (cnt_q == CW'(W)) ? par_q : sout;
`else
  assign ser_out = sout;
`endif

endmodule
